// File: rtl/fifo_arb_pkg.sv
// Shared types, defaults and the round-robin pick function for the FIFO
// write-port arbiter.
package fifo_arb_pkg;

    // Arbiter FSM states; the encoding is fixed so grant state is easy to probe.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Default sizing of the arbiter.
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 8;

    // Widest requester vector the pick function handles.
    localparam int MAX_REQ = 8;

    // Round-robin winner: scan req starting one past 'last', wrapping at
    // 'num', and return the first set index. Returns 0 when nothing is set;
    // callers qualify the result with an any-request flag.
    function automatic int unsigned rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        num,
        input int unsigned        last
    );
        int unsigned win;
        int unsigned idx;
        logic        found;
        win   = 0;
        idx   = 0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if ((k <= num) && !found) begin
                idx = (last + k) % num;
                if (|(req & (MAX_REQ'(1) << idx))) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: rotates the request vector to start one
// past the last owner and priority-encodes the first valid requester.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_vld,
    input  logic [ID_W-1:0]    rr_last,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    // Pick the next requester after rr_last, wrapping around NUM_REQ.
    always_comb begin
        winner  = ID_W'(rr_pick(MAX_REQ'(req_vld), NUM_REQ, 32'(rr_last)));
        any_req = |req_vld;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the dual-clock FIFO write side (clk_a).
// One requester owns the FIFO at a time for a burst of up to MAX_BURST words;
// the FIFO full flag back-pressures the owner without ever dropping a word.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int ID_W       = 2,
    parameter int CNT_W      = 8
) (
    input  logic                          clk_a,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic                          fifo_full,
    output logic [FIFO_WIDTH-1:0]         fifo_din,
    output logic                          fifo_wen,
    output logic [NUM_REQ-1:0]            grant_oh,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    // Architectural state.
    arb_state_e         state_q,     state_d;
    logic [ID_W-1:0]    owner_q,     owner_d;
    logic [ID_W-1:0]    rr_last_q,   rr_last_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

    // Registered grant outputs, aligned with state_q.
    logic [NUM_REQ-1:0] grant_oh_q,  grant_oh_d;
    logic [ID_W-1:0]    grant_id_q,  grant_id_d;
    logic               busy_q,      busy_d;

    // Arbitration and handshake helpers.
    logic [ID_W-1:0]    pick_id;
    logic               any_req;
    logic               owner_vld;
    logic               xfer;
    logic               last_beat;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_vld (req_vld),
        .rr_last (rr_last_q),
        .winner  (pick_id),
        .any_req (any_req)
    );

    // Owner datapath: select the owner's valid/data and drive the handshake.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        owner_vld = 1'b0;
        fifo_din  = '0;
        req_rdy   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == ID_W'(i)) begin
                owner_vld  = req_vld[i];
                fifo_din   = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
                req_rdy[i] = (state_q == BURST) && !fifo_full;
            end
        end
        // A write never happens while full, so the FIFO cannot drop a word.
        xfer     = (state_q == BURST) && owner_vld && !fifo_full;
        fifo_wen = xfer;
    end

    // Burst length compare is unsigned; MAX_BURST=1 ends on the first word.
    always_comb begin
        last_beat = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
    end

    // Next-state logic: grant in IDLE, count and release in BURST.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                // One bubble cycle per grant: rdy/wen stay low while picking.
                if (any_req) begin
                    owner_d     = pick_id;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                // Release on a dropped valid (even when stalled) or on the
                // final word of the burst. A full stall simply holds here.
                if (!owner_vld || (xfer && last_beat)) begin
                    state_d     = IDLE;
                    rr_last_d   = owner_q;
                    burst_cnt_d = '0;
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Grant outputs are registered from the next state so they line up
        // with state_q; they read as zero while idle.
        busy_d     = (state_d == BURST);
        grant_id_d = busy_d ? owner_d : '0;
        grant_oh_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (busy_d && (owner_d == ID_W'(i))) begin
                grant_oh_d[i] = 1'b1;
            end
        end
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk_a) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_last_q   <= ID_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            grant_oh_q  <= '0;
            grant_id_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            burst_cnt_q <= burst_cnt_d;
            grant_oh_q  <= grant_oh_d;
            grant_id_q  <= grant_id_d;
            busy_q      <= busy_d;
        end
    end

    // Drive the registered grant outputs.
    always_comb begin
        grant_oh = grant_oh_q;
        grant_id = grant_id_q;
        busy     = busy_q;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: scenario tasks plus a reference
// model that tracks the arbiter as "who owns the FIFO and how many words
// they have written", and a queue standing in for the FIFO.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int FIFO_WIDTH = 16;
    localparam int MAX_BURST  = 8;
    localparam int ID_W       = 2;
    localparam int CNT_W      = 8;
    localparam int DW         = NUM_REQ * FIFO_WIDTH;

    logic                  clk_a = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_vld;
    logic [DW-1:0]         req_data;
    logic [NUM_REQ-1:0]    req_rdy;
    logic                  fifo_full;
    logic [FIFO_WIDTH-1:0] fifo_din;
    logic                  fifo_wen;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [ID_W-1:0]       grant_id;
    logic                  busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Sampled DUT outputs for the current cycle.
    logic                  obs_wen, obs_busy;
    logic [FIFO_WIDTH-1:0] obs_din;
    logic [NUM_REQ-1:0]    obs_rdy, obs_goh;
    logic [ID_W-1:0]       obs_gid;

    // Reference model state and its predictions.
    bit                    m_busy  = 1'b0;
    int                    m_owner = 0;
    int                    m_last  = NUM_REQ - 1;
    int                    m_cnt   = 0;
    bit                    exp_wen, exp_busy;
    logic [FIFO_WIDTH-1:0] exp_din;
    logic [NUM_REQ-1:0]    exp_rdy, exp_goh;
    logic [ID_W-1:0]       exp_gid;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .FIFO_WIDTH (FIFO_WIDTH),
        .MAX_BURST  (MAX_BURST),
        .ID_W       (ID_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_a     (clk_a),
        .rst_n     (rst_n),
        .req_vld   (req_vld),
        .req_data  (req_data),
        .req_rdy   (req_rdy),
        .fifo_full (fifo_full),
        .fifo_din  (fifo_din),
        .fifo_wen  (fifo_wen),
        .grant_oh  (grant_oh),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk_a = ~clk_a;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] rand_data();
        return {$urandom(), $urandom()};
    endfunction

    // Model predictions for this cycle from ownership and current inputs.
    task automatic model_outputs();
        exp_busy = m_busy;
        exp_gid  = m_busy ? ID_W'(m_owner) : '0;
        exp_goh  = m_busy ? NUM_REQ'(1 << m_owner) : '0;
        exp_rdy  = (m_busy && !fifo_full) ? NUM_REQ'(1 << m_owner) : '0;
        exp_wen  = m_busy && req_vld[m_owner] && !fifo_full;
        exp_din  = req_data[m_owner*FIFO_WIDTH +: FIFO_WIDTH];
    endtask

    // Model advance at the clock edge: grant, count words, release.
    task automatic model_step();
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_last  = NUM_REQ - 1;
            m_cnt   = 0;
        end else if (!m_busy) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int r;
                r = (m_last + k) % NUM_REQ;
                if (req_vld[r]) begin
                    m_owner = r;
                    m_cnt   = 0;
                    m_busy  = 1'b1;
                    break;
                end
            end
        end else if (!req_vld[m_owner]) begin
            m_busy = 1'b0;
            m_last = m_owner;
            m_cnt  = 0;
        end else if (!fifo_full) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == MAX_BURST) begin
                m_busy = 1'b0;
                m_last = m_owner;
                m_cnt  = 0;
            end
        end
    endtask

    // Apply inputs, sample outputs at the falling edge, then clock DUT and model.
    task automatic run_cycle(input logic [NUM_REQ-1:0] vld, input logic full, input logic rstn);
        req_vld   = vld;
        fifo_full = full;
        rst_n     = rstn;
        @(negedge clk_a);
        obs_wen  = fifo_wen;
        obs_din  = fifo_din;
        obs_rdy  = req_rdy;
        obs_goh  = grant_oh;
        obs_gid  = grant_id;
        obs_busy = busy;
        model_outputs();
        @(posedge clk_a);
        model_step();
        cyc++;
        #1;
    endtask

    function automatic bit model_ok();
        return (obs_wen === exp_wen) && (obs_rdy === exp_rdy) && (obs_goh === exp_goh) &&
               (obs_gid === exp_gid) && (obs_busy === exp_busy) &&
               (!exp_busy || (obs_din === exp_din));
    endfunction

    function automatic string diff_str();
        return $sformatf("cyc=%0d wen=%b want %b rdy=%b want %b goh=%b want %b gid=%0d want %0d busy=%b want %b din=%h want %h",
                         cyc, obs_wen, exp_wen, obs_rdy, exp_rdy, obs_goh, exp_goh,
                         obs_gid, exp_gid, obs_busy, exp_busy, obs_din, exp_din);
    endfunction

    task automatic do_reset();
        req_data = rand_data();
        run_cycle('0, 1'b0, 1'b0);
        run_cycle('0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        req_data = rand_data();
        run_cycle(4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            req_data = rand_data();
            run_cycle(4'b1111, 1'b0, 1'b0);
            n_cmp++;
            if (obs_goh !== 4'b0000 || obs_wen !== 1'b0 || obs_rdy !== 4'b0000 || obs_busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_outputs cyc=%0d goh=%b wen=%b rdy=%b busy=%b want all 0",
                         cyc, obs_goh, obs_wen, obs_rdy, obs_busy);
            end
        end
        for (int i = 0; i < 2; i++) begin
            req_data = rand_data();
            run_cycle(4'b1111, 1'b0, 1'b1);
            n_cmp++;
            if (!model_ok()) begin n_err++; $display("FAIL reset_model %s", diff_str()); end
        end
        n_cmp++;
        if (obs_busy !== 1'b1 || obs_gid !== 2'd0) begin
            n_err++;
            $display("FAIL reset_first_grant busy=%b gid=%0d want busy=1 gid=0", obs_busy, obs_gid);
        end
    endtask

    task automatic test_round_robin();
        int grants[$];
        int words[$];
        int gaps[$];
        int idle_run;
        logic prev_busy;
        int want_order[5];
        want_order = '{0, 1, 2, 3, 0};
        idle_run  = 0;
        prev_busy = 1'b0;
        do_reset();
        for (int c = 0; c < 46; c++) begin
            req_data = rand_data();
            run_cycle(4'b1111, 1'b0, 1'b1);
            n_cmp++;
            if (!model_ok()) begin n_err++; $display("FAIL rr_model %s", diff_str()); end
            if (obs_busy && !prev_busy) begin
                grants.push_back(int'(obs_gid));
                words.push_back(0);
                gaps.push_back(idle_run);
                idle_run = 0;
            end
            if (!obs_busy) idle_run++;
            if (obs_wen && words.size() > 0) words[words.size()-1]++;
            prev_busy = obs_busy;
        end
        n_cmp++;
        if (grants.size() < 5) begin
            n_err++;
            $display("FAIL rr_grant_count got %0d grants want at least 5", grants.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (grants[i] != want_order[i]) begin
                    n_err++;
                    $display("FAIL rr_order idx=%0d got %0d want %0d", i, grants[i], want_order[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (words[i] != MAX_BURST) begin
                    n_err++;
                    $display("FAIL rr_burst_len burst=%0d got %0d want %0d", i, words[i], MAX_BURST);
                end
                n_cmp++;
                if (gaps[i+1] != 1) begin
                    n_err++;
                    $display("FAIL rr_bubble burst=%0d got %0d idle cycles want 1", i + 1, gaps[i+1]);
                end
            end
        end
    endtask

    task automatic test_early_release();
        int   wcnt;
        logic dropped;
        logic [NUM_REQ-1:0] v;
        wcnt    = 0;
        dropped = 1'b0;
        do_reset();
        for (int c = 0; c < 12 && !dropped; c++) begin
            v = (wcnt < 3) ? 4'b0100 : 4'b0000;
            req_data = rand_data();
            run_cycle(v, 1'b0, 1'b1);
            n_cmp++;
            if (!model_ok()) begin n_err++; $display("FAIL early_model %s", diff_str()); end
            if (obs_wen) wcnt++;
            if (v == 4'b0000 && obs_busy) dropped = 1'b1;
        end
        n_cmp++;
        if (!dropped || wcnt != 3) begin
            n_err++;
            $display("FAIL early_wen_count got %0d pulses (dropped=%b) want 3", wcnt, dropped);
        end
        req_data = rand_data();
        run_cycle(4'b1001, 1'b0, 1'b1);
        n_cmp++;
        if (obs_busy !== 1'b0 || obs_wen !== 1'b0) begin
            n_err++;
            $display("FAIL early_busy_fall busy=%b wen=%b want 0 0", obs_busy, obs_wen);
        end
        req_data = rand_data();
        run_cycle(4'b1001, 1'b0, 1'b1);
        n_cmp++;
        if (obs_busy !== 1'b1 || obs_gid !== 2'd3) begin
            n_err++;
            $display("FAIL early_next_grant busy=%b gid=%0d want busy=1 gid=3", obs_busy, obs_gid);
        end
    endtask

    task automatic test_full_stall();
        int   wcnt, stall_left;
        logic full, was_full, was_busy, ended;
        wcnt = 0; stall_left = 5; was_full = 1'b0; was_busy = 1'b0; ended = 1'b0;
        do_reset();
        for (int c = 0; c < 30 && !ended; c++) begin
            full = (wcnt == 4) && (stall_left > 0);
            req_data = rand_data();
            run_cycle(4'b0010, full, 1'b1);
            n_cmp++;
            if (!model_ok()) begin n_err++; $display("FAIL stall_model %s", diff_str()); end
            if (full) begin
                stall_left--;
                n_cmp++;
                if (obs_rdy !== 4'b0000 || obs_wen !== 1'b0 || obs_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_hold rdy=%b wen=%b busy=%b want 0000 0 1", obs_rdy, obs_wen, obs_busy);
                end
            end else if (was_full) begin
                n_cmp++;
                if (obs_wen !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_resume wen=%b want 1", obs_wen);
                end
            end
            if (obs_wen) wcnt++;
            if (was_busy && !obs_busy) ended = 1'b1;
            was_busy = obs_busy;
            was_full = full;
        end
        n_cmp++;
        if (!ended || wcnt != MAX_BURST || stall_left != 0) begin
            n_err++;
            $display("FAIL stall_total words=%0d ended=%b stalls_left=%0d want %0d 1 0",
                     wcnt, ended, stall_left, MAX_BURST);
        end
    endtask

    task automatic test_reset_mid_burst();
        int wcnt;
        wcnt = 0;
        do_reset();
        for (int c = 0; c < 15 && wcnt < 5; c++) begin
            req_data = rand_data();
            run_cycle(4'b0010, 1'b0, 1'b1);
            n_cmp++;
            if (!model_ok()) begin n_err++; $display("FAIL midrst_model %s", diff_str()); end
            if (obs_wen) wcnt++;
        end
        n_cmp++;
        if (wcnt != 5 || obs_gid !== 2'd1) begin
            n_err++;
            $display("FAIL midrst_setup words=%0d gid=%0d want 5 1", wcnt, obs_gid);
        end
        req_data = rand_data();
        run_cycle(4'b0010, 1'b0, 1'b0);
        req_data = rand_data();
        run_cycle(4'b1111, 1'b0, 1'b1);
        n_cmp++;
        if (obs_busy !== 1'b0 || obs_goh !== 4'b0000 || obs_wen !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_idle busy=%b goh=%b wen=%b want 0 0000 0", obs_busy, obs_goh, obs_wen);
        end
        req_data = rand_data();
        run_cycle(4'b1111, 1'b0, 1'b1);
        n_cmp++;
        if (obs_busy !== 1'b1 || obs_gid !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_regrant busy=%b gid=%0d want 1 0", obs_busy, obs_gid);
        end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] v;
        logic full;
        v = '0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 3) == 0) v[i] = ~v[i];
            end
            full = ($urandom_range(0, 3) == 0);
            req_data = rand_data();
            run_cycle(v, full, 1'b1);
            n_cmp++;
            if (!model_ok()) begin n_err++; $display("FAIL random_model %s", diff_str()); end
        end
    endtask

    task automatic test_end_to_end();
        logic [FIFO_WIDTH-1:0] q[$];
        logic [FIFO_WIDTH-1:0] w;
        int   sent[2];
        int   rx_next[2];
        int   idx;
        logic done;
        sent = '{0, 0}; rx_next = '{0, 0}; done = 1'b0;
        do_reset();
        for (int c = 0; c < 4000 && !done; c++) begin
            req_data = {32'h0, 16'hB000 + 16'(sent[1]), 16'hA000 + 16'(sent[0])};
            run_cycle({2'b00, sent[1] < 64, sent[0] < 64}, q.size() >= 8, 1'b1);
            n_cmp++;
            if (!model_ok()) begin n_err++; $display("FAIL e2e_model %s", diff_str()); end
            for (int i = 0; i < 2; i++) begin
                if (req_vld[i] && obs_rdy[i]) sent[i]++;
            end
            if (obs_wen) q.push_back(obs_din);
            if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
                w   = q.pop_front();
                idx = (w[15:12] == 4'hA) ? 0 : (w[15:12] == 4'hB) ? 1 : -1;
                n_cmp++;
                if (idx < 0) begin
                    n_err++;
                    $display("FAIL e2e_tag word=%h want tag A or B", w);
                end else if (int'(w[11:0]) != rx_next[idx]) begin
                    n_err++;
                    $display("FAIL e2e_order req=%0d got seq %0d want %0d", idx, w[11:0], rx_next[idx]);
                    rx_next[idx] = int'(w[11:0]) + 1;
                end else begin
                    rx_next[idx]++;
                end
            end
            done = (sent[0] >= 64) && (sent[1] >= 64) && (q.size() == 0);
        end
        n_cmp++;
        if (!done || rx_next[0] != 64 || rx_next[1] != 64) begin
            n_err++;
            $display("FAIL e2e_complete done=%b rxA=%0d rxB=%0d want 1 64 64", done, rx_next[0], rx_next[1]);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_vld   = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        test_reset();
        test_round_robin();
        test_early_release();
        test_full_stall();
        test_reset_mid_burst();
        test_random();
        test_end_to_end();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
